// File: rtl/voice_allocator.sv
// voice_allocator
//   Maps keyboard note-on/note-off events onto NUM_VOICES oscillator voices.
//   A new note takes the least-recently-used free voice. When every voice is
//   gated, the oldest voice is stolen instead.
//
// Ports
//   clock          system clock; all logic is on posedge
//   reset          asynchronous, active-high; clears all state
//   evt_valid      key event present
//   evt_ready      event can be accepted (high only in idle)
//   evt_on         1 = press, 0 = release
//   evt_code       key scan code; 0 is reserved and is discarded
//   all_off        synchronous panic; drops all gates and aborts any event
//   voice_gate     per-voice gate
//   voice_code     per-voice note code; voice i at [i*CODE_W +: CODE_W]
//   voice_trigger  one-cycle retrigger pulse per voice
//   busy           inverse of evt_ready
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CODE_W     = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         evt_valid,
    output logic                         evt_ready,
    input  logic                         evt_on,
    input  logic [CODE_W-1:0]            evt_code,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*CODE_W-1:0] voice_code,
    output logic [NUM_VOICES-1:0]        voice_trigger,
    output logic                         busy
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StAlloc, StSteal, StCommit} state_e;

    state_e                state_q, state_d;
    logic                  on_q;
    logic [CODE_W-1:0]     ev_code_q;
    idx_t                  victim_q, victim_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic [CODE_W-1:0]     code_q [NUM_VOICES];
    logic [CODE_W-1:0]     code_d [NUM_VOICES];
    // Age rank: 0 = newest, NUM_VOICES-1 = oldest. Always a permutation.
    idx_t                  rank_q [NUM_VOICES];
    idx_t                  rank_d [NUM_VOICES];

    logic                  accept;
    logic [NUM_VOICES-1:0] match;
    logic                  any_match, any_free;
    idx_t                  match_idx, free_idx, free_rank, oldest_idx;

    assign evt_ready = (state_q == StIdle);
    assign busy      = ~evt_ready;
    assign accept    = evt_valid & evt_ready;

    // Voice lookup against the latched event.
    always_comb begin
        match      = '0;
        any_match  = 1'b0;
        any_free   = 1'b0;
        match_idx  = '0;
        free_idx   = '0;
        free_rank  = '0;
        oldest_idx = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (gate_q[i] && (code_q[i] == ev_code_q)) begin
                match[i] = 1'b1;
                // Lowest-index gated match wins for retrigger.
                if (!any_match) begin
                    any_match = 1'b1;
                    match_idx = idx_t'(i);
                end
            end
            if (!gate_q[i] && (!any_free || (rank_q[i] > free_rank))) begin
                any_free  = 1'b1;
                free_idx  = idx_t'(i);
                free_rank = rank_q[i];
            end
            if (rank_q[i] == idx_t'(NUM_VOICES - 1)) begin
                oldest_idx = idx_t'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Code 0 is accepted but discarded.
                if (accept && (evt_code != '0)) begin
                    state_d = StAlloc;
                end
            end
            StAlloc: begin
                if (!on_q || any_match) begin
                    state_d = StIdle;
                end else if (any_free) begin
                    state_d = StCommit;
                end else begin
                    state_d = StSteal;
                end
            end
            StSteal:  state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (all_off) begin
            state_d = StIdle;
        end
    end

    // Voice datapath next-state.
    always_comb begin
        gate_d   = gate_q;
        trig_d   = '0;
        code_d   = code_q;
        rank_d   = rank_q;
        victim_d = victim_q;
        unique case (state_q)
            StAlloc: begin
                if (!on_q) begin
                    gate_d = gate_q & ~match;
                end else if (any_match) begin
                    trig_d[match_idx] = 1'b1;
                end else if (any_free) begin
                    victim_d = free_idx;
                end else begin
                    // Steal: drop the gate first so the ADSR sees a falling edge.
                    victim_d           = oldest_idx;
                    gate_d[oldest_idx] = 1'b0;
                end
            end
            StSteal: begin
                code_d[victim_q] = ev_code_q;
            end
            StCommit: begin
                code_d[victim_q] = ev_code_q;
                gate_d[victim_q] = 1'b1;
                trig_d[victim_q] = 1'b1;
                for (int i = 0; i < int'(NUM_VOICES); i++) begin
                    if (rank_q[i] < rank_q[victim_q]) begin
                        rank_d[i] = rank_q[i] + 1'b1;
                    end
                end
                rank_d[victim_q] = '0;
            end
            default: ;
        endcase
        // Panic aborts any in-flight event; codes and ages are left alone.
        if (all_off) begin
            gate_d = '0;
            trig_d = '0;
            code_d = code_q;
            rank_d = rank_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            on_q      <= 1'b0;
            ev_code_q <= '0;
            victim_q  <= '0;
            gate_q    <= '0;
            trig_q    <= '0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                code_q[i] <= '0;
                rank_q[i] <= idx_t'(i);
            end
        end else begin
            if (accept) begin
                on_q      <= evt_on;
                ev_code_q <= evt_code;
            end
            victim_q <= victim_d;
            gate_q   <= gate_d;
            trig_q   <= trig_d;
            code_q   <= code_d;
            rank_q   <= rank_d;
        end
    end

    always_comb begin
        voice_code = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            voice_code[i*CODE_W +: CODE_W] = code_q[i];
        end
    end

    assign voice_gate    = gate_q;
    assign voice_trigger = trig_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    logic        clock;
    logic        reset;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_on;
    logic [7:0]  evt_code;
    logic        all_off;
    logic [3:0]  voice_gate;
    logic [31:0] voice_code;
    logic [3:0]  voice_trigger;
    logic        busy;

    int checks;
    int failures;

    // Per-event trace recorded by send(): sample k is taken 1 time unit after edge E_k.
    logic [3:0]  s_gate [8];
    logic [31:0] s_code [8];
    int          s_busy;
    int          s_n;
    int          s_pulses;
    logic [3:0]  s_trig_or;

    voice_allocator #(
        .NUM_VOICES(4),
        .CODE_W    (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_on       (evt_on),
        .evt_code     (evt_code),
        .all_off      (all_off),
        .voice_gate   (voice_gate),
        .voice_code   (voice_code),
        .voice_trigger(voice_trigger),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic record();
        s_gate[s_n] = voice_gate;
        s_code[s_n] = voice_code;
        s_trig_or   = s_trig_or | voice_trigger;
        s_pulses    = s_pulses + $countones(voice_trigger);
        s_n++;
    endtask

    task automatic apply_reset();
        evt_valid = 1'b0;
        evt_on    = 1'b0;
        evt_code  = 8'h00;
        all_off   = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Present an event, hold it until ready returns, then trace one extra cycle.
    task automatic send(input logic on, input logic [7:0] code);
        evt_valid = 1'b1;
        evt_on    = on;
        evt_code  = code;
        s_n       = 0;
        s_busy    = 0;
        s_pulses  = 0;
        s_trig_or = 4'b0;
        step();
        record();
        while (!evt_ready && s_busy < 6) begin
            s_busy++;
            step();
            record();
        end
        evt_valid = 1'b0;
        step();
        record();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        evt_valid = 1'b0;
        all_off = 1'b0;
        #3;
        checks++; if (voice_gate !== 4'b0) begin failures++;
            $display("FAIL reset_gate got=%b want=%b", voice_gate, 4'b0); end
        checks++; if (voice_code !== 32'h0) begin failures++;
            $display("FAIL reset_code got=%h want=%h", voice_code, 32'h0); end
        checks++; if (voice_trigger !== 4'b0) begin failures++;
            $display("FAIL reset_trigger got=%b want=%b", voice_trigger, 4'b0); end
        checks++; if (evt_ready !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_ready got=%b/%b want=1/0", evt_ready, busy); end
        step();
        reset = 1'b0;
    endtask

    // Three notes land on voices 3, 2, 1 in that order.
    task automatic test_alloc_free();
        logic [7:0] codes [3];
        codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            send(1'b1, codes[k]);
            checks++; if (s_busy !== 2) begin failures++;
                $display("FAIL alloc_busy[%0d] got=%0d want=2", k, s_busy); end
            checks++; if (s_trig_or !== 4'(1 << (3 - k)) || s_pulses !== 1) begin failures++;
                $display("FAIL alloc_trig[%0d] got=%b/%0d want=%b/1", k, s_trig_or, s_pulses,
                         4'(1 << (3 - k))); end
            checks++; if (s_code[2][(3-k)*8 +: 8] !== codes[k] || s_gate[2][3-k] !== 1'b1)
            begin failures++;
                $display("FAIL alloc_latency[%0d] got=%h/%b want=%h/1", k,
                         s_code[2][(3-k)*8 +: 8], s_gate[2][3-k], codes[k]); end
        end
        checks++; if (voice_gate !== 4'b1110 || voice_code !== 32'h1C1B2300) begin failures++;
            $display("FAIL alloc_final got=%b/%h want=1110/1c1b2300", voice_gate, voice_code); end
    endtask

    // Continues from test_alloc_free: fill voice 0, then steal voice 3.
    task automatic test_steal();
        send(1'b1, 8'h2B);
        checks++; if (voice_gate !== 4'b1111 || voice_code !== 32'h1C1B232B) begin failures++;
            $display("FAIL steal_fill got=%b/%h want=1111/1c1b232b", voice_gate, voice_code); end
        send(1'b1, 8'h34);
        checks++; if (s_busy !== 3) begin failures++;
            $display("FAIL steal_busy got=%0d want=3", s_busy); end
        checks++; if (s_gate[1] !== 4'b0111 || s_code[1][31:24] !== 8'h1C) begin failures++;
            $display("FAIL steal_e1 got=%b/%h want=0111/1c", s_gate[1], s_code[1][31:24]); end
        checks++; if (s_gate[2] !== 4'b0111 || s_code[2][31:24] !== 8'h34) begin failures++;
            $display("FAIL steal_e2 got=%b/%h want=0111/34", s_gate[2], s_code[2][31:24]); end
        checks++; if (s_gate[3] !== 4'b1111 || s_trig_or !== 4'b1000 || s_pulses !== 1)
        begin failures++;
            $display("FAIL steal_e3 got=%b/%b/%0d want=1111/1000/1", s_gate[3], s_trig_or,
                     s_pulses); end
    endtask

    // Continues from test_steal: release voice 2, then it is the only free voice.
    task automatic test_off();
        send(1'b0, 8'h1B);
        checks++; if (s_busy !== 1 || s_gate[1] !== 4'b1011 || s_pulses !== 0) begin failures++;
            $display("FAIL off_gate got=%0d/%b/%0d want=1/1011/0", s_busy, s_gate[1],
                     s_pulses); end
        checks++; if (voice_code !== 32'h341B232B) begin failures++;
            $display("FAIL off_code_kept got=%h want=341b232b", voice_code); end
        send(1'b1, 8'h42);
        checks++; if (voice_gate !== 4'b1111 || voice_code !== 32'h3442232B ||
                      s_trig_or !== 4'b0100) begin failures++;
            $display("FAIL off_realloc got=%b/%h/%b want=1111/3442232b/0100", voice_gate,
                     voice_code, s_trig_or); end
    endtask

    task automatic test_retrigger();
        apply_reset();
        send(1'b1, 8'h1C);
        send(1'b1, 8'h1C);
        checks++; if (s_busy !== 1 || s_trig_or !== 4'b1000 || s_pulses !== 1) begin failures++;
            $display("FAIL retrig_pulse got=%0d/%b/%0d want=1/1000/1", s_busy, s_trig_or,
                     s_pulses); end
        checks++; if (voice_gate !== 4'b1000 || voice_code !== 32'h1C000000) begin failures++;
            $display("FAIL retrig_state got=%b/%h want=1000/1c000000", voice_gate,
                     voice_code); end
        send(1'b0, 8'h55);
        checks++; if (s_busy !== 1 || s_pulses !== 0 || voice_gate !== 4'b1000 ||
                      voice_code !== 32'h1C000000) begin failures++;
            $display("FAIL off_unheld got=%0d/%0d/%b/%h want=1/0/1000/1c000000", s_busy,
                     s_pulses, voice_gate, voice_code); end
    endtask

    task automatic test_all_off();
        apply_reset();
        send(1'b1, 8'h1C);
        send(1'b1, 8'h1B);
        send(1'b1, 8'h23);
        send(1'b1, 8'h2B);
        evt_valid = 1'b1;
        evt_on    = 1'b1;
        evt_code  = 8'h34;
        step();  // E0: accepted, ALLOC
        step();  // E1: STEAL
        checks++; if (voice_gate !== 4'b0111 || evt_ready !== 1'b0) begin failures++;
            $display("FAIL alloff_pre got=%b/%b want=0111/0", voice_gate, evt_ready); end
        all_off = 1'b1;
        step();  // E2: panic
        all_off   = 1'b0;
        evt_valid = 1'b0;
        checks++; if (voice_gate !== 4'b0 || evt_ready !== 1'b1 || voice_trigger !== 4'b0)
        begin failures++;
            $display("FAIL alloff_now got=%b/%b/%b want=0000/1/0000", voice_gate, evt_ready,
                     voice_trigger); end
        checks++; if (voice_code !== 32'h1C1B232B) begin failures++;
            $display("FAIL alloff_code got=%h want=1c1b232b", voice_code); end
        step();
        checks++; if (voice_gate !== 4'b0 || voice_trigger !== 4'b0 || evt_ready !== 1'b1)
        begin failures++;
            $display("FAIL alloff_after got=%b/%b/%b want=0000/0000/1", voice_gate,
                     voice_trigger, evt_ready); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(1'b1, 8'h1C);
        evt_valid = 1'b1;
        evt_on    = 1'b1;
        evt_code  = 8'h1B;
        step();  // E0: ALLOC
        #2;
        reset = 1'b1;
        #1;
        checks++; if (voice_gate !== 4'b0 || voice_code !== 32'h0 || voice_trigger !== 4'b0 ||
                      evt_ready !== 1'b1) begin failures++;
            $display("FAIL mid_reset got=%b/%h/%b/%b want=0000/00000000/0000/1", voice_gate,
                     voice_code, voice_trigger, evt_ready); end
        evt_valid = 1'b0;
        step();
        reset = 1'b0;
        send(1'b1, 8'h23);
        send(1'b1, 8'h00);
        checks++; if (s_busy !== 0 || s_pulses !== 0 || voice_gate !== 4'b1000 ||
                      voice_code !== 32'h23000000) begin failures++;
            $display("FAIL code_zero got=%0d/%0d/%b/%h want=0/0/1000/23000000", s_busy,
                     s_pulses, voice_gate, voice_code); end
    endtask

    // Random events against an event-level model: gates, codes and an LRU list
    // of voice indices (front = most recently allocated).
    task automatic test_random();
        logic [3:0]  mg;
        logic [7:0]  mc [4];
        int          lru [$];
        logic        on;
        logic [7:0]  code;
        int          exp_busy;
        logic [3:0]  exp_trig;
        int          hit;
        int          v;
        apply_reset();
        mg  = 4'b0;
        for (int i = 0; i < 4; i++) mc[i] = 8'h00;
        lru = '{0, 1, 2, 3};
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                all_off = 1'b1;
                step();
                all_off = 1'b0;
                mg = 4'b0;
                checks++; if (voice_gate !== 4'b0 || evt_ready !== 1'b1) begin failures++;
                    $display("FAIL rnd_alloff[%0d] got=%b/%b want=0000/1", n, voice_gate,
                             evt_ready); end
                continue;
            end
            on       = ($urandom_range(0, 9) < 6);
            code     = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'h10 + 8'($urandom_range(0, 5));
            exp_trig = 4'b0;
            v        = -1;
            if (code == 8'h00) begin
                exp_busy = 0;
            end else if (!on) begin
                exp_busy = 1;
                for (int i = 0; i < 4; i++) if (mg[i] && mc[i] == code) mg[i] = 1'b0;
            end else begin
                hit = -1;
                for (int i = 3; i >= 0; i--) if (mg[i] && mc[i] == code) hit = i;
                if (hit >= 0) begin
                    exp_busy      = 1;
                    exp_trig[hit] = 1'b1;
                end else begin
                    for (int p = lru.size() - 1; p >= 0; p--) begin
                        if (!mg[lru[p]]) begin
                            v = lru[p];
                            break;
                        end
                    end
                    if (v < 0) begin
                        v        = lru[lru.size() - 1];
                        exp_busy = 3;
                    end else begin
                        exp_busy = 2;
                    end
                    mc[v]       = code;
                    mg[v]       = 1'b1;
                    exp_trig[v] = 1'b1;
                    for (int p = 0; p < lru.size(); p++) begin
                        if (lru[p] == v) begin
                            lru.delete(p);
                            break;
                        end
                    end
                    lru.push_front(v);
                end
            end
            send(on, code);
            checks++; if (s_busy !== exp_busy) begin failures++;
                $display("FAIL rnd_busy[%0d] got=%0d want=%0d", n, s_busy, exp_busy); end
            checks++; if (s_trig_or !== exp_trig || s_pulses !== $countones(exp_trig))
            begin failures++;
                $display("FAIL rnd_trig[%0d] got=%b/%0d want=%b/%0d", n, s_trig_or, s_pulses,
                         exp_trig, $countones(exp_trig)); end
            checks++; if (voice_gate !== mg) begin failures++;
                $display("FAIL rnd_gate[%0d] got=%b want=%b", n, voice_gate, mg); end
            checks++; if (voice_code !== {mc[3], mc[2], mc[1], mc[0]}) begin failures++;
                $display("FAIL rnd_code[%0d] got=%h want=%h", n, voice_code,
                         {mc[3], mc[2], mc[1], mc[0]}); end
            if (exp_busy == 3) begin
                checks++; if (s_gate[1][v] !== 1'b0) begin failures++;
                    $display("FAIL rnd_steal_gap[%0d] got=%b want=0", n, s_gate[1][v]); end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        evt_valid = 1'b0;
        evt_on    = 1'b0;
        evt_code  = 8'h00;
        all_off   = 1'b0;
        test_reset();
        test_alloc_free();
        test_steal();
        test_off();
        test_retrigger();
        test_all_off();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
